// File: rtl/rainbow_scroller.sv
// rtl/rainbow_scroller.sv - pipelined column-to-RGB rainbow generator with scrolling and brightness
//
// Purpose:
//   Maps a requested column to an RGB colour on a three-segment hue ramp of
//   period P = 3*SEG_LEN. A frame-synchronised hue offset gives scrolling
//   (either direction) or a solid colour that cycles over time, and a global
//   brightness scales every channel. The fixed latency is three clocks and
//   there is no backpressure.
//
// Ports:
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   frame_tick - one-cycle pulse at frame start; samples mode, advances divider
//   mode       - 0 static, 1 scroll, 2 solid-hue cycle, 3 behaves as 0
//   reverse    - scroll direction (0 offset counts up, 1 counts down)
//   brightness - global gain, all-ones means unity
//   req_valid  - column request strobe
//   req_column - requested column
//   out_valid  - result strobe, three cycles after req_valid
//   red/green/blue - scaled colour channels, held while out_valid is low
//   offset     - current hue offset, 0..P-1
module rainbow_scroller #(
  parameter int SEG_LEN         = 21,
  parameter int STEP            = 3,
  parameter int COLOR_BITS      = 6,
  parameter int COL_W           = 8,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_tick,
  input  logic [1:0]            mode,
  input  logic                  reverse,
  input  logic [COLOR_BITS-1:0] brightness,
  input  logic                  req_valid,
  input  logic [COL_W-1:0]      req_column,
  output logic                  out_valid,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue,
  output logic [COL_W-1:0]      offset
);

  localparam int P     = 3 * SEG_LEN;
  localparam int MAX   = (1 << COLOR_BITS) - 1;
  localparam int DIV_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [COL_W-1:0] P_LAST   = COL_W'(P - 1);
  localparam logic [COL_W:0]   P_WIDE   = (COL_W + 1)'(P);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAMES_PER_STEP - 1);

  // ---------------------------------------------------------------------
  // Frame-synchronised mode, divider and hue offset
  // ---------------------------------------------------------------------
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] div_q;
  logic             moving;

  assign moving = (mode_q == 2'd1) || (mode_q == 2'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= 2'd0;
      div_q  <= '0;
      offset <= '0;
    end else if (frame_tick) begin
      mode_q <= mode;
      // The divider advances on the mode that was in force for the frame
      // just ending, so a mode change takes effect one frame later.
      if (moving) begin
        if (div_q == DIV_LAST) begin
          div_q <= '0;
          if (reverse) begin
            offset <= (offset == '0) ? P_LAST : offset - 1'b1;
          end else begin
            offset <= (offset == P_LAST) ? '0 : offset + 1'b1;
          end
        end else begin
          div_q <= div_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // S1: out-of-range detect and hue position
  // ---------------------------------------------------------------------
  logic             s1_valid;
  logic             s1_oob;
  logic [COL_W-1:0] s1_pos;

  logic             oob_d;
  logic [COL_W-1:0] off_eff;
  logic [COL_W:0]   sum_d;
  logic [COL_W:0]   wrap_d;
  logic [COL_W-1:0] pos_d;

  always_comb begin
    oob_d   = ({1'b0, req_column} >= P_WIDE);
    off_eff = moving ? offset : '0;
    sum_d   = {1'b0, req_column} + {1'b0, off_eff};
    wrap_d  = (sum_d >= P_WIDE) ? (sum_d - P_WIDE) : sum_d;
    pos_d   = '0;
    // Out-of-range columns are parked at position 0 so the later stages
    // only ever see in-range indices; their colour is forced off in S2.
    if (!oob_d) begin
      if (mode_q == 2'd2) begin
        pos_d = offset;
      end else begin
        pos_d = COL_W'(wrap_d);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_oob   <= 1'b0;
      s1_pos   <= '0;
    end else begin
      s1_valid <= req_valid;
      s1_oob   <= oob_d;
      s1_pos   <= pos_d;
    end
  end

  // ---------------------------------------------------------------------
  // S2: segment select and clamped ramps
  // ---------------------------------------------------------------------
  logic                  s2_valid;
  logic [COLOR_BITS-1:0] s2_r;
  logic [COLOR_BITS-1:0] s2_g;
  logic [COLOR_BITS-1:0] s2_b;

  int                    pos_i;
  int                    seg_i;
  int                    idx_i;
  int                    rise_i;
  int                    fall_i;
  logic [COLOR_BITS-1:0] rise;
  logic [COLOR_BITS-1:0] fall;
  logic [COLOR_BITS-1:0] r_d;
  logic [COLOR_BITS-1:0] g_d;
  logic [COLOR_BITS-1:0] b_d;

  always_comb begin
    pos_i = int'(s1_pos);
    if (pos_i < SEG_LEN) begin
      seg_i = 0;
    end else if (pos_i < 2 * SEG_LEN) begin
      seg_i = 1;
    end else begin
      seg_i = 2;
    end
    idx_i  = pos_i - seg_i * SEG_LEN;
    // Ramps are computed in 32-bit arithmetic so nothing wraps before the clamp.
    rise_i = idx_i * STEP;
    fall_i = (SEG_LEN - idx_i) * STEP;
    if (rise_i > MAX) rise_i = MAX;
    if (fall_i > MAX) fall_i = MAX;
    rise = COLOR_BITS'(rise_i);
    fall = COLOR_BITS'(fall_i);

    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (!s1_oob) begin
      case (seg_i)
        0: begin
          r_d = fall;
          g_d = rise;
        end
        1: begin
          g_d = fall;
          b_d = rise;
        end
        default: begin
          r_d = rise;
          b_d = fall;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_r     <= '0;
      s2_g     <= '0;
      s2_b     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_r     <= r_d;
      s2_g     <= g_d;
      s2_b     <= b_d;
    end
  end

  // ---------------------------------------------------------------------
  // S3: brightness scaling and output register
  // ---------------------------------------------------------------------
  // (ch * (brightness + 1)) >> COLOR_BITS; the product of a COLOR_BITS value
  // and a gain of at most 2**COLOR_BITS always fits in 2*COLOR_BITS bits.
  function automatic logic [COLOR_BITS-1:0] scale(
    input logic [COLOR_BITS-1:0] ch,
    input logic [COLOR_BITS-1:0] br
  );
    logic [COLOR_BITS:0]     gain;
    logic [2*COLOR_BITS-1:0] prod;
    gain  = {1'b0, br} + (COLOR_BITS + 1)'(1);
    prod  = (2 * COLOR_BITS)'(ch) * (2 * COLOR_BITS)'(gain);
    return COLOR_BITS'(prod >> COLOR_BITS);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        red   <= scale(s2_r, brightness);
        green <= scale(s2_g, brightness);
        blue  <= scale(s2_b, brightness);
      end
    end
  end

endmodule
